// File: rtl/record_capture_writer_pkg.sv
// record_capture_writer_pkg: shared sizes, note/record types, FSM states and slot-id check for the record capture writer
package record_capture_writer_pkg;
  localparam int KEYS = 8;
  localparam int REC_LEN = 32;
  localparam int PLAY_RECS_MAX = 8;
  localparam int TICK_W = 16;
  typedef struct packed {
    logic [KEYS-1:0] keys;
    logic [TICK_W-1:0] ticks;
  } note_event_t;
  typedef struct packed {
    note_event_t [REC_LEN-1:0] notes;
    logic [7:0] length;
  } play_record_t;
  typedef enum logic [1:0] {IDLE, CAPTURE, COMMIT} state_t;
  function automatic logic id_valid(input logic [7:0] id);
    return id != 8'd0 && id <= 8'(PLAY_RECS_MAX);
  endfunction
endpackage

// File: rtl/record_capture_writer_if.sv
// record_capture_writer_if: keyboard-side inputs (tick_en, keys_in, start, target_id, stop) and storage-side outputs (write_record_id, new_record_data, busy, done, overflow, error, event_count); master = driver, slave = writer
interface record_capture_writer_if;
  import record_capture_writer_pkg::*;
  logic tick_en;
  logic [KEYS-1:0] keys_in;
  logic start;
  logic [7:0] target_id;
  logic stop;
  logic [7:0] write_record_id;
  play_record_t new_record_data;
  logic busy;
  logic done;
  logic overflow;
  logic error;
  logic [7:0] event_count;
  modport master (
    output tick_en, keys_in, start, target_id, stop,
    input write_record_id, new_record_data, busy, done, overflow, error, event_count
  );
  modport slave (
    input tick_en, keys_in, start, target_id, stop,
    output write_record_id, new_record_data, busy, done, overflow, error, event_count
  );
endinterface

// File: rtl/record_capture_writer_encoder.sv
// record_capture_writer_encoder: run-length encoder holding the open event; ports clk, rst, load_i, tick_i, flush_i, keys_i in; store_o pulse with ev_o out
module record_capture_writer_encoder
  import record_capture_writer_pkg::*;
#(
  parameter int TW = TICK_W
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_i,
  input  logic            tick_i,
  input  logic            flush_i,
  input  logic [KEYS-1:0] keys_i,
  output logic            store_o,
  output note_event_t     ev_o
);
  logic [KEYS-1:0] keys_q, keys_d;
  logic [TW-1:0] ticks_q, ticks_d;
  logic live, restart;
  always_comb begin
    live = ticks_q != '0;
    restart = !live || keys_i != keys_q || &ticks_q;
    store_o = live && (flush_i || (tick_i && restart));
    keys_d = (load_i || tick_i) ? keys_i : keys_q;
    ticks_d = load_i ? '0 : tick_i ? (restart ? TW'(1) : ticks_q + TW'(1)) : ticks_q;
    ev_o = {keys_q, TICK_W'(ticks_q)};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      keys_q <= '0;
      ticks_q <= '0;
    end else begin
      keys_q <= keys_d;
      ticks_q <= ticks_d;
    end
  end
endmodule

// File: rtl/record_capture_writer.sv
// record_capture_writer: captures key activity as run-length events and commits the record to storage; ports clk, sys_rst, bus (slave modport of record_capture_writer_if)
module record_capture_writer
  import record_capture_writer_pkg::*;
#(
  parameter int TW = TICK_W
) (
  input logic clk,
  input logic sys_rst,
  record_capture_writer_if.slave bus
);
  localparam int IW = $clog2(REC_LEN);
  state_t state_q, state_d;
  logic [7:0] id_q, id_d, cnt_q, cnt_d;
  note_event_t [REC_LEN-1:0] notes_q, notes_d;
  logic ovf_q, ovf_d, done_q, done_d, err_q, err_d;
  logic accept, capturing, store, full;
  note_event_t ev;
  assign capturing = state_q == CAPTURE;
  record_capture_writer_encoder #(.TW(TW)) u_enc (
    .clk(clk),
    .rst(sys_rst),
    .load_i(accept),
    .tick_i(capturing && bus.tick_en && !bus.stop),
    .flush_i(capturing && bus.stop),
    .keys_i(bus.keys_in),
    .store_o(store),
    .ev_o(ev)
  );
  always_comb begin
    accept = state_q == IDLE && bus.start && id_valid(bus.target_id);
    full = cnt_q == 8'(REC_LEN - 1);
    state_d = state_q;
    id_d = id_q;
    cnt_d = cnt_q;
    notes_d = notes_q;
    ovf_d = ovf_q;
    done_d = state_q == COMMIT;
    err_d = state_q == IDLE && bus.start && !id_valid(bus.target_id);
    if (accept) begin
      state_d = CAPTURE;
      id_d = bus.target_id;
      cnt_d = '0;
      notes_d = '0;
      ovf_d = 1'b0;
    end
    if (capturing && store) begin
      notes_d[cnt_q[IW-1:0]] = ev;
      cnt_d = cnt_q + 8'd1;
    end
    if (capturing && (bus.stop || (store && full))) state_d = COMMIT;
    if (capturing && !bus.stop && store && full) ovf_d = 1'b1;
    if (state_q == COMMIT) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q <= IDLE;
      id_q <= '0;
      cnt_q <= '0;
      notes_q <= '0;
      ovf_q <= 1'b0;
      done_q <= 1'b0;
      err_q <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q <= id_d;
      cnt_q <= cnt_d;
      notes_q <= notes_d;
      ovf_q <= ovf_d;
      done_q <= done_d;
      err_q <= err_d;
    end
  end
  assign bus.write_record_id = state_q == COMMIT ? id_q : '0;
  assign bus.new_record_data = {notes_q, cnt_q};
  assign bus.busy = state_q != IDLE;
  assign bus.done = done_q;
  assign bus.overflow = ovf_q;
  assign bus.error = err_q;
  assign bus.event_count = cnt_q;
endmodule

// File: tb/tb_record_capture_writer.sv
// tb_record_capture_writer: directed takes checked every cycle against a run-length model of the capture rules
module tb_record_capture_writer;
  import record_capture_writer_pkg::*;
  localparam int TW = 4;
  localparam int TMAX = (1 << TW) - 1;
  logic clk = 1'b0;
  logic sys_rst = 1'b1;
  record_capture_writer_if bus();
  record_capture_writer #(.TW(TW)) dut (.clk(clk), .sys_rst(sys_rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int fails = 0;
  task automatic chk(input string name, input logic [799:0] act, input logic [799:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  int mode = 0;
  logic [7:0] m_id = '0;
  logic [KEYS-1:0] masks[$];
  note_event_t evs[$];
  logic [7:0] e_wid = '0;
  logic [7:0] e_cnt = '0;
  logic e_busy = 1'b0, e_done = 1'b0, e_err = 1'b0, e_ovf = 1'b0;
  play_record_t e_rec = '0;
  bit armed = 1'b0;
  task automatic rebuild();
    evs.delete();
    foreach (masks[i]) begin
      int last = evs.size() - 1;
      if (last >= 0 && evs[last].keys == masks[i] && int'(evs[last].ticks) < TMAX) begin
        note_event_t t = evs[last];
        t.ticks = t.ticks + 16'd1;
        evs[last] = t;
      end else evs.push_back({masks[i], 16'd1});
    end
  endtask
  task automatic image(input int n);
    e_rec = '0;
    for (int i = 0; i < n; i++) e_rec.notes[i] = evs[i];
    e_rec.length = 8'(n);
  endtask
  task automatic model_edge(input logic rs, input logic tk, input logic st, input logic sp,
                            input logic [7:0] id, input logic [KEYS-1:0] k);
    e_done = 1'b0;
    e_err = 1'b0;
    e_wid = '0;
    if (rs) begin
      mode = 0;
      e_ovf = 1'b0;
      e_rec = '0;
      masks.delete();
    end else if (mode == 2) begin
      mode = 0;
      e_done = 1'b1;
    end else if (mode == 0) begin
      if (st && int'(id) >= 1 && int'(id) <= PLAY_RECS_MAX) begin
        mode = 1;
        m_id = id;
        masks.delete();
        e_ovf = 1'b0;
        e_rec = '0;
      end else if (st) e_err = 1'b1;
    end else if (sp) begin
      rebuild();
      image(evs.size());
      mode = 2;
      e_wid = m_id;
    end else if (tk) begin
      masks.push_back(k);
      rebuild();
      if (evs.size() - 1 >= REC_LEN) begin
        image(REC_LEN);
        e_ovf = 1'b1;
        mode = 2;
        e_wid = m_id;
      end else image(evs.size() - 1);
    end
    e_busy = mode != 0;
    e_cnt = e_rec.length;
  endtask
  int wr_n = 0, done_n = 0, err_n = 0;
  logic [7:0] last_wid = '0;
  play_record_t last_rec = '0;
  always @(negedge clk) begin
    if (armed) begin
      chk("write_record_id", bus.write_record_id, e_wid);
      chk("busy", bus.busy, e_busy);
      chk("done", bus.done, e_done);
      chk("error", bus.error, e_err);
      chk("overflow", bus.overflow, e_ovf);
      chk("event_count", bus.event_count, e_cnt);
      chk("new_record_data", bus.new_record_data, e_rec);
      if (bus.write_record_id != 8'd0) begin
        wr_n++;
        last_wid = bus.write_record_id;
        last_rec = bus.new_record_data;
      end
      if (bus.done) done_n++;
      if (bus.error) err_n++;
    end
  end
  logic [KEYS-1:0] cur_k = '0;
  task automatic cyc(input logic rs, input logic tk, input logic [KEYS-1:0] k, input logic st,
                     input logic [7:0] id, input logic sp);
    sys_rst = rs;
    bus.tick_en = tk;
    bus.keys_in = k;
    bus.start = st;
    bus.target_id = id;
    bus.stop = sp;
    cur_k = k;
    @(posedge clk);
    model_edge(rs, tk, st, sp, id, k);
    armed = 1'b1;
    #1;
  endtask
  task automatic tick(input logic [KEYS-1:0] k);
    cyc(1'b0, 1'b1, k, 1'b0, 8'd0, 1'b0);
  endtask
  task automatic idle();
    cyc(1'b0, 1'b0, cur_k, 1'b0, 8'd0, 1'b0);
  endtask
  task automatic begin_take(input logic [7:0] id);
    cyc(1'b0, 1'b0, cur_k, 1'b1, id, 1'b0);
  endtask
  task automatic end_take();
    cyc(1'b0, 1'b0, cur_k, 1'b0, 8'd0, 1'b1);
    repeat (3) idle();
  endtask
  initial begin
    repeat (2) cyc(1'b1, 1'b0, 8'h00, 1'b0, 8'd0, 1'b0);
    idle();
    chk("reset record zero", bus.new_record_data, '0);
    begin_take(8'd3);
    repeat (5) begin
      tick(8'h01);
      idle();
    end
    repeat (2) tick(8'h00);
    end_take();
    chk("t1 writes", wr_n, 1);
    chk("t1 id", last_wid, 8'd3);
    chk("t1 length", last_rec.length, 8'd2);
    chk("t1 ev0", last_rec.notes[0], {8'h01, 16'd5});
    chk("t1 ev1", last_rec.notes[1], {8'h00, 16'd2});
    chk("t1 done", done_n, 1);
    begin_take(8'd0);
    idle();
    begin_take(8'd9);
    idle();
    chk("bad id errors", err_n, 2);
    chk("bad id no write", wr_n, 1);
    begin_take(8'd5);
    repeat (9) tick(8'h80);
    cyc(1'b0, 1'b1, 8'h80, 1'b1, 8'd9, 1'b0);
    repeat (10) tick(8'h80);
    end_take();
    chk("sat writes", wr_n, 2);
    chk("sat id", last_wid, 8'd5);
    chk("sat length", last_rec.length, 8'd2);
    chk("sat ev0", last_rec.notes[0], {8'h80, 16'd15});
    chk("sat ev1", last_rec.notes[1], {8'h80, 16'd5});
    chk("busy start no error", err_n, 2);
    begin_take(8'd6);
    for (int i = 1; i <= 40; i++) tick((i % 2 == 1) ? 8'h55 : 8'hAA);
    end_take();
    chk("full writes once", wr_n, 3);
    chk("full id", last_wid, 8'd6);
    chk("full length", last_rec.length, 8'd32);
    chk("full overflow", bus.overflow, 1'b1);
    chk("full ev0", last_rec.notes[0], {8'h55, 16'd1});
    chk("full ev31", last_rec.notes[31], {8'hAA, 16'd1});
    begin_take(8'd2);
    tick(8'h01);
    tick(8'h02);
    tick(8'h03);
    tick(8'h04);
    chk("pre-reset count", bus.event_count, 8'd3);
    cyc(1'b1, 1'b0, 8'h04, 1'b0, 8'd0, 1'b0);
    repeat (2) idle();
    chk("reset no write", wr_n, 3);
    chk("reset clears record", bus.new_record_data, '0);
    begin_take(8'd7);
    repeat (3) tick(8'h11);
    end_take();
    chk("after reset writes", wr_n, 4);
    chk("after reset id", last_wid, 8'd7);
    chk("after reset ev0", last_rec.notes[0], {8'h11, 16'd3});
    begin_take(8'd4);
    repeat (2) tick(8'h0F);
    cyc(1'b0, 1'b1, 8'hF0, 1'b0, 8'd0, 1'b1);
    repeat (3) idle();
    chk("stop+tick writes", wr_n, 5);
    chk("stop+tick id", last_wid, 8'd4);
    chk("stop+tick length", last_rec.length, 8'd1);
    chk("stop+tick ev0", last_rec.notes[0], {8'h0F, 16'd2});
    chk("stop+tick ev1 empty", last_rec.notes[1], 24'd0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end
endmodule

// File: doc/record_capture_writer.md
Name: record_capture_writer

Overview:
- Client-side writer for the play-record store. Captures live key activity during a free-play take and compresses it into run-length note events.
- On stop, or when the record buffer is full, commits the assembled record to the record storage manager with a one-cycle write-id strobe.
- Sits between the debounced keyboard input and the record storage manager, on the same clock as both.

Parameters:
- KEYS, 8, number of piano keys sampled; width of one key mask.
- REC_LEN, 32, maximum note events per PlayRecord.
- RECS_MAX, 8, number of storage slots. Valid ids are 1..RECS_MAX.
- TICK_W, 16, width of the per-event duration counter.

Ports:
- clk  in  1  system clock.
- sys_rst  in  1  synchronous, active-high reset.
- tick_en  in  1  one-cycle timebase pulse; duration unit.
- keys_in  in  KEYS  debounced key mask (1 = pressed).
- start  in  1  one-cycle request to begin a take.
- target_id  in  8  destination slot id, sampled with start.
- stop  in  1  one-cycle request to end the take.
- write_record_id  out  8  storage write strobe. Nonzero for exactly one cycle = write slot id-1; 0 = no write.
- new_record_data  out  PlayRecord  record image presented to storage.
- busy  out  1  high in CAPTURE and COMMIT.
- done  out  1  one-cycle pulse, the cycle after the write strobe.
- overflow  out  1  sticky until next accepted start; take ended because the buffer was full.
- error  out  1  one-cycle pulse; start rejected.
- event_count  out  8  events stored so far.

Behaviour:
- Reset: all outputs 0, new_record_data all-zero, state IDLE. Reset mid-take discards the take; no write is issued.
- States: IDLE -> CAPTURE -> COMMIT -> IDLE.
- IDLE, start with target_id in 1..RECS_MAX:
  - latch the id;
  - clear the record image, event_count and overflow;
  - cur_keys <= keys_in, cur_ticks <= 0;
  - go to CAPTURE next cycle.
- IDLE, start with target_id 0 or > RECS_MAX: error pulses next cycle; stay in IDLE.
- start while busy is ignored; no error.
- CAPTURE, on each tick_en (evaluate in priority order):
  - cur_ticks == 0: cur_keys <= keys_in, cur_ticks <= 1.
  - keys_in != cur_keys: store event {cur_keys, cur_ticks} at index event_count, event_count++, cur_keys <= keys_in, cur_ticks <= 1.
  - cur_ticks == 2^TICK_W-1: store the saturated event; start a new event with the same keys, cur_ticks <= 1.
  - otherwise: cur_ticks++.
- Rests (keys == 0) are recorded as ordinary events.
- Buffer full: if a store brings event_count to REC_LEN, set overflow and go to COMMIT next cycle. The open event is dropped.
- Stop:
  - stop in CAPTURE has priority over a same-cycle tick_en; that tick is not counted.
  - If cur_ticks > 0 and event_count < REC_LEN, the open event is stored first.
  - Go to COMMIT next cycle.
  - stop outside CAPTURE is ignored.
- COMMIT: write_record_id = latched id for exactly one cycle, with new_record_data stable and length field = event_count. Next cycle: done = 1, state IDLE.
- new_record_data holds its value after commit until the next accepted start.
- write_record_id is 0 in every other cycle, including reset.
- The storage write takes one cycle and has no acknowledge; the writer never retries.

Decomposition:
- Shared package (header.svh):
  - NoteEvent struct {logic [KEYS-1:0] keys; logic [TICK_W-1:0] ticks;}.
  - PlayRecord struct {NoteEvent notes[REC_LEN]; byte length;}.
  - Constants PLAY_RECS_MAX and REC_LEN.
  - State enum.
- Sub-module event_run_length_encoder: holds cur_keys/cur_ticks and emits a store pulse with the event. The top module owns the FSM, record image and storage strobe.

Test Plan:
- Start id=3; keys 0x01 held for 5 ticks, then 0x00 for 2 ticks; stop -> events {0x01,5},{0x00,2}; length=2; write_record_id=3 for one cycle; done the next cycle.
- Start id=0, and separately id=9 -> error pulse each time; busy stays 0; write_record_id stays 0.
- Run with TICK_W=4; hold 0x80 for 20 ticks; stop -> events {0x80,15},{0x80,5}.
- Toggle keys on every tick for 40 ticks with REC_LEN=32 -> auto-commit at event 32; overflow=1; stop after that is ignored.
- Assert sys_rst during CAPTURE after 3 events -> no write strobe; all outputs 0; a following valid take writes correctly.
- Assert stop and tick_en in the same cycle with a key change -> the tick is not counted; only the prior event is stored; commit follows.
